// File: rtl/rv32i_multicycle_core_v2.sv
// Multicycle RV32I core with configurable memory wait states, enable stall and sticky halt.
// One instruction at a time: fetch, decode, then an execute/memory path that ends in retire.
package rv32i_multicycle_core_v2_pkg;
   localparam logic [3:0] MMU_BANK_INST = 4'h1;

   typedef enum logic [1:0] {
      MEM_ACCESS_WORD    = 2'd0,
      MEM_ACCESS_HALF    = 2'd1,
      MEM_ACCESS_BYTE    = 2'd2,
      MEM_ACCESS_INVALID = 2'd3
   } mem_access_t;

   typedef logic [3:0] mem_exception_mask_t;

   typedef enum logic [3:0] {
      ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL,
      ALU_SRA, ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU
   } alu_control_t;

   localparam logic [6:0] OP_REG    = 7'h33;
   localparam logic [6:0] OP_IMM    = 7'h13;
   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_AUIPC  = 7'h17;
   localparam logic [6:0] OP_JAL    = 7'h6F;
   localparam logic [6:0] OP_JALR   = 7'h67;
   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_BRANCH = 7'h63;

   function automatic alu_control_t alu_decode(input logic [2:0] funct3, input logic alt);
      case (funct3)
         3'b000:  return alt ? ALU_SUB : ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return alt ? ALU_SRA : ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

   function automatic logic [31:0] alu_eval(input alu_control_t op, input logic [31:0] a,
                                            input logic [31:0] b);
      case (op)
         ALU_AND:  return a & b;
         ALU_OR:   return a | b;
         ALU_XOR:  return a ^ b;
         ALU_SLL:  return a << b[4:0];
         ALU_SRL:  return a >> b[4:0];
         ALU_SRA:  return $signed(a) >>> b[4:0];
         ALU_SUB:  return a - b;
         ALU_SLT:  return {31'd0, $signed(a) < $signed(b)};
         ALU_SLTU: return {31'd0, a < b};
         default:  return a + b;
      endcase
   endfunction
endpackage

// state      | meaning
// S_FETCH    | read instruction at PC for 1+W cycles
// S_DECODE   | read operands, precompute branch/jump target
// S_EXECUTE  | ALU, LUI, AUIPC, JALR
// S_ALUWB    | write rd, advance PC, retire
// S_MEMADR   | compute load/store address
// S_MEMREAD  | load access for 1+W cycles
// S_MEMWB    | write extended load data, retire
// S_MEMWRITE | store access for 1+W cycles, retire on last
// S_BRANCH   | compare and select PC, retire
// S_HALT     | sticky stop until reset
module rv32i_multicycle_core_v2
   import rv32i_multicycle_core_v2_pkg::*;
#(
   parameter logic [31:0] PC_START_ADDRESS = {MMU_BANK_INST, 28'h0},
   parameter int          MEM_WAIT_CYCLES  = 0,
   parameter int          COUNT_WIDTH      = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ena,
   output logic [31:0]            mem_addr,
   input  logic [31:0]            mem_rd_data,
   output logic [31:0]            mem_wr_data,
   output logic                   mem_wr_ena,
   output mem_access_t            mem_access,
   input  mem_exception_mask_t    mem_exception,
   output logic [31:0]            PC,
   output logic [COUNT_WIDTH-1:0] instructions_completed,
   output logic                   instruction_done,
   output logic                   halted
);
   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_EXECUTE, S_ALUWB, S_MEMADR,
      S_MEMREAD, S_MEMWB, S_MEMWRITE, S_BRANCH, S_HALT
   } state_t;

   localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT_CYCLES);

   state_t                 state_q, state_d;
   logic [3:0]             wait_q, wait_d;
   logic [31:0]            pc_q, pc_d, pc_old_q, pc_old_d, pc_next_q, pc_next_d;
   logic [31:0]            ir_q, ir_d, a_q, a_d, b_q, b_d;
   logic [31:0]            alu_last_q, alu_last_d, mem_data_q, mem_data_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;
   logic [31:0]            rf_q [32];

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [4:0]  rd_idx;
   logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
   logic [31:0] rs1_val, rs2_val, rd_wdata;
   logic        reg_write, wr_req, retire, dwell_last, fault, br_eq, br_lt, br_taken, ls_legal;
   mem_access_t ls_size;

   assign opcode  = ir_q[6:0];
   assign funct3  = ir_q[14:12];
   assign rd_idx  = ir_q[11:7];
   assign imm_i   = {{20{ir_q[31]}}, ir_q[31:20]};
   assign imm_s   = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
   assign imm_b   = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
   assign imm_j   = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
   assign imm_u   = {ir_q[31:12], 12'd0};
   assign rs1_val = rf_q[ir_q[19:15]];
   assign rs2_val = rf_q[ir_q[24:20]];

   assign dwell_last = (wait_q == WAIT_LAST);
   assign fault      = dwell_last && (mem_exception != '0);
   assign br_eq      = (a_q == b_q);
   assign br_lt      = (alu_eval(funct3[1] ? ALU_SLTU : ALU_SLT, a_q, b_q) != 32'd0);
   assign br_taken   = funct3[2] ? (br_lt ^ funct3[0]) : (br_eq ^ funct3[0]);
   assign ls_size    = (funct3[1:0] == 2'b00) ? MEM_ACCESS_BYTE :
                       (funct3[1:0] == 2'b01) ? MEM_ACCESS_HALF : MEM_ACCESS_WORD;
   assign ls_legal   = (opcode == OP_STORE) ? (funct3 <= 3'd2) :
                       (funct3 != 3'd3 && funct3 != 3'd6 && funct3 != 3'd7);

   always_comb begin
      state_d    = state_q;
      wait_d     = '0;
      pc_d       = pc_q;
      pc_old_d   = pc_old_q;
      pc_next_d  = pc_next_q;
      ir_d       = ir_q;
      a_d        = a_q;
      b_d        = b_q;
      alu_last_d = alu_last_q;
      mem_data_d = mem_data_q;
      count_d    = count_q;
      mem_addr   = pc_q;
      mem_access = MEM_ACCESS_WORD;
      wr_req     = 1'b0;
      reg_write  = 1'b0;
      rd_wdata   = alu_last_q;
      retire     = 1'b0;
      case (state_q)
         S_FETCH: begin
            if (!dwell_last) begin
               wait_d = wait_q + 4'd1;
            end else if (fault) begin
               state_d = S_HALT;
            end else begin
               ir_d      = mem_rd_data;
               pc_old_d  = pc_q;
               pc_next_d = pc_q + 32'd4;
               state_d   = S_DECODE;
            end
         end
         S_DECODE: begin
            a_d        = rs1_val;
            b_d        = rs2_val;
            alu_last_d = pc_old_q + ((opcode == OP_JAL) ? imm_j : imm_b);
            case (opcode)
               OP_REG, OP_IMM, OP_LUI, OP_AUIPC, OP_JALR: state_d = S_EXECUTE;
               OP_JAL: begin
                  pc_next_d = pc_old_q + imm_j;
                  state_d   = S_ALUWB;
               end
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_BRANCH:         state_d = S_BRANCH;
               default:           state_d = S_HALT;
            endcase
         end
         S_EXECUTE: begin
            state_d = S_ALUWB;
            case (opcode)
               OP_REG:   alu_last_d = alu_eval(alu_decode(funct3, ir_q[30]), a_q, b_q);
               OP_IMM:   alu_last_d = alu_eval(alu_decode(funct3, (funct3 == 3'b101) && ir_q[30]),
                                               a_q, imm_i);
               OP_LUI:   alu_last_d = 32'd0 + imm_u;
               OP_AUIPC: alu_last_d = pc_old_q + imm_u;
               default: begin
                  pc_next_d  = (a_q + imm_i) & ~32'd1;
                  alu_last_d = pc_old_q + 32'd4;
               end
            endcase
         end
         S_ALUWB: begin
            reg_write = 1'b1;
            rd_wdata  = (opcode == OP_JAL) ? pc_old_q + 32'd4 : alu_last_q;
            pc_d      = pc_next_q;
            retire    = 1'b1;
            state_d   = S_FETCH;
         end
         S_MEMADR: begin
            if (!ls_legal) begin
               state_d = S_HALT;
            end else if (opcode == OP_STORE) begin
               alu_last_d = a_q + imm_s;
               state_d    = S_MEMWRITE;
            end else begin
               alu_last_d = a_q + imm_i;
               state_d    = S_MEMREAD;
            end
         end
         S_MEMREAD: begin
            mem_addr   = alu_last_q;
            mem_access = ls_size;
            if (!dwell_last) begin
               wait_d = wait_q + 4'd1;
            end else if (fault) begin
               state_d = S_HALT;
            end else begin
               mem_data_d = mem_rd_data;
               state_d    = S_MEMWB;
            end
         end
         S_MEMWB: begin
            reg_write = 1'b1;
            case (funct3)
               3'b000:  rd_wdata = {{24{mem_data_q[7]}}, mem_data_q[7:0]};
               3'b001:  rd_wdata = {{16{mem_data_q[15]}}, mem_data_q[15:0]};
               3'b100:  rd_wdata = {24'd0, mem_data_q[7:0]};
               3'b101:  rd_wdata = {16'd0, mem_data_q[15:0]};
               default: rd_wdata = mem_data_q;
            endcase
            pc_d    = pc_next_q;
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         S_MEMWRITE: begin
            mem_addr   = alu_last_q;
            mem_access = ls_size;
            wr_req     = !fault;
            if (!dwell_last) begin
               wait_d = wait_q + 4'd1;
            end else if (fault) begin
               state_d = S_HALT;
            end else begin
               pc_d    = pc_next_q;
               retire  = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_BRANCH: begin
            if (funct3[2:1] == 2'b01) begin
               state_d = S_HALT;
            end else begin
               pc_d    = br_taken ? alu_last_q : pc_next_q;
               retire  = 1'b1;
               state_d = S_FETCH;
            end
         end
         default: state_d = S_HALT;
      endcase
      if (retire) count_d = count_q + 1'b1;
   end

   assign mem_wr_data            = b_q;
   assign mem_wr_ena             = wr_req && ena;
   assign instruction_done       = retire && ena;
   assign halted                 = (state_q == S_HALT);
   assign PC                     = pc_q;
   assign instructions_completed = count_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_FETCH;
         wait_q     <= '0;
         pc_q       <= PC_START_ADDRESS;
         pc_old_q   <= PC_START_ADDRESS;
         pc_next_q  <= PC_START_ADDRESS;
         ir_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         alu_last_q <= '0;
         mem_data_q <= '0;
         count_q    <= '0;
      end else if (ena) begin
         state_q    <= state_d;
         wait_q     <= wait_d;
         pc_q       <= pc_d;
         pc_old_q   <= pc_old_d;
         pc_next_q  <= pc_next_d;
         ir_q       <= ir_d;
         a_q        <= a_d;
         b_q        <= b_d;
         alu_last_q <= alu_last_d;
         mem_data_q <= mem_data_d;
         count_q    <= count_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 32; i++) rf_q[i] <= '0;
      end else if (reg_write && ena && rd_idx != 5'd0) begin
         rf_q[rd_idx] <= rd_wdata;
      end
   end
endmodule

// File: tb/tb_rv32i_multicycle_core_v2.sv
// Directed program bench for rv32i_multicycle_core_v2 with two memory wait states.
module tb_rv32i_multicycle_core_v2;
   import rv32i_multicycle_core_v2_pkg::*;

   localparam int          W = 2;
   localparam logic [31:0] S = 32'h1000_0000;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                ena = 1'b1;
   logic [31:0]         mem_addr, mem_rd_data, mem_wr_data, PC, instructions_completed;
   logic                mem_wr_ena, instruction_done, halted;
   mem_access_t         mem_access;
   mem_exception_mask_t mem_exception;

   logic [31:0] mem [256];
   logic [31:0] img [256];
   logic        load = 1'b0;
   logic        exc_arm = 1'b0;
   int          wr_run = 0;
   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] exp_count = '0;
   logic [31:0] rword, rsh, fill;

   rv32i_multicycle_core_v2 #(.MEM_WAIT_CYCLES(W)) dut (
      .clk(clk), .rst(rst_n), .ena(ena), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
      .mem_wr_data(mem_wr_data), .mem_wr_ena(mem_wr_ena), .mem_access(mem_access),
      .mem_exception(mem_exception), .PC(PC), .instructions_completed(instructions_completed),
      .instruction_done(instruction_done), .halted(halted)
   );

   always #5 clk = ~clk;

   assign mem_exception = (exc_arm && mem_addr == 32'h200) ? 4'h2 : 4'h0;

   always_comb begin
      rword = mem[mem_addr[9:2]];
      rsh   = rword >> {mem_addr[1:0], 3'b000};
      case (mem_access)
         MEM_ACCESS_BYTE: mem_rd_data = {24'd0, rsh[7:0]};
         MEM_ACCESS_HALF: mem_rd_data = {16'd0, rsh[15:0]};
         default:         mem_rd_data = rword;
      endcase
   end

   // memory commits a write only once the strobe has been held for the full dwell
   always @(posedge clk) begin
      if (load) begin
         for (int i = 0; i < 256; i++) mem[i] <= img[i];
         wr_run <= 0;
      end else if (mem_wr_ena) begin
         if (wr_run == W) begin
            case (mem_access)
               MEM_ACCESS_BYTE: mem[mem_addr[9:2]][{mem_addr[1:0], 3'b000} +: 8] <= mem_wr_data[7:0];
               MEM_ACCESS_HALF: mem[mem_addr[9:2]][{mem_addr[1], 4'b0000} +: 16] <= mem_wr_data[15:0];
               default:         mem[mem_addr[9:2]] <= mem_wr_data;
            endcase
            wr_run <= 0;
         end else begin
            wr_run <= wr_run + 1;
         end
      end else begin
         wr_run <= 0;
      end
   end

   function automatic logic [31:0] i_t(input int imm, input int rs1, input int f3, input int rd,
                                       input logic [6:0] op);
      return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
   endfunction
   function automatic logic [31:0] s_t(input int imm, input int rs2, input int rs1, input int f3);
      return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
   endfunction
   function automatic logic [31:0] b_t(input int imm, input int rs2, input int rs1, input int f3);
      return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
   endfunction
   function automatic logic [31:0] j_t(input int imm, input int rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6F};
   endfunction
   function automatic logic [31:0] u_t(input int imm, input int rd, input logic [6:0] op);
      return {imm[19:0], rd[4:0], op};
   endfunction
   function automatic logic [31:0] r_t(input int f7, input int rs2, input int rs1, input int f3,
                                       input int rd);
      return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
   endfunction

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic load_image();
      load = 1'b1;
      @(posedge clk);
      #1 load = 1'b0;
   endtask

   task automatic run_instr(input string tag, input int exp_cyc, input int exp_wr,
                            input logic [31:0] exp_pc, input int stall_at, input int stall_len);
      int n, wr;
      bit done;
      n = 0; wr = 0; done = 1'b0;
      while (!done && n < 200) begin
         n++;
         if (n == stall_at) ena = 1'b0;
         if (n == stall_at + stall_len) ena = 1'b1;
         #1;
         if (mem_wr_ena) wr++;
         if (instruction_done) done = 1'b1;
         else @(negedge clk);
      end
      ena = 1'b1;
      check32({tag, " retired"}, 32'(done), 32'd1);
      check32({tag, " cycles"}, n, exp_cyc);
      check32({tag, " wr_cycles"}, wr, exp_wr);
      @(negedge clk);
      #1;
      exp_count++;
      check32({tag, " pc"}, PC, exp_pc);
      check32({tag, " count"}, instructions_completed, exp_count);
   endtask

   task automatic halt_check(input string tag, input int exp_cyc, input logic [31:0] exp_pc);
      int n, dn, wr;
      bit seen;
      n = 0; dn = 0; wr = 0; seen = 1'b0;
      while (!seen && n < 100) begin
         n++;
         #1;
         if (instruction_done) dn++;
         if (mem_wr_ena) wr++;
         if (halted) seen = 1'b1;
         else @(negedge clk);
      end
      check32({tag, " halt_seen"}, 32'(seen), 32'd1);
      check32({tag, " halt_cycle"}, n, exp_cyc);
      repeat (20) begin
         @(negedge clk);
         #1;
         if (instruction_done) dn++;
         if (mem_wr_ena) wr++;
      end
      check32({tag, " halted_held"}, 32'(halted), 32'd1);
      check32({tag, " done_pulses"}, dn, 0);
      check32({tag, " wr_cycles"}, wr, 0);
      check32({tag, " count_frozen"}, instructions_completed, exp_count);
      check32({tag, " pc_frozen"}, PC, exp_pc);
   endtask

   initial begin
      #100_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      fill = s_t(12'h220, 1, 0, 2);
      for (int i = 0; i < 256; i++) img[i] = 32'd0;
      img[0]  = i_t(5, 0, 0, 1, OP_IMM);
      img[1]  = r_t(0, 1, 1, 0, 2);
      img[2]  = s_t(12'h200, 2, 0, 2);
      img[3]  = i_t(-128, 0, 0, 4, OP_IMM);
      img[4]  = s_t(12'h204, 4, 0, 0);
      img[5]  = i_t(12'h204, 0, 0, 3, OP_LOAD);
      img[6]  = i_t(12'h204, 0, 4, 5, OP_LOAD);
      img[7]  = s_t(12'h208, 3, 0, 2);
      img[8]  = s_t(12'h20C, 5, 0, 2);
      img[9]  = j_t(16, 6);
      img[10] = s_t(12'h210, 6, 0, 2);
      img[11] = b_t(16, 1, 1, 0);
      img[12] = fill;
      img[13] = i_t(1, 6, 0, 0, OP_JALR);
      img[14] = fill;
      img[15] = b_t(8, 1, 1, 1);
      img[16] = b_t(8, 1, 4, 4);
      img[17] = fill;
      img[18] = b_t(8, 1, 4, 6);
      img[19] = j_t(12, 0);
      img[20] = j_t(12, 0);
      img[21] = fill;
      img[22] = b_t(-8, 1, 1, 0);
      img[23] = u_t(20'hABCDE, 8, OP_LUI);
      img[24] = u_t(1, 9, OP_AUIPC);
      img[25] = s_t(12'h214, 8, 0, 2);
      img[26] = s_t(12'h218, 9, 0, 2);
      img[27] = r_t(7'h20, 2, 1, 0, 10);
      img[28] = i_t(12'h401, 10, 5, 11, OP_IMM);
      img[29] = s_t(12'h21C, 11, 0, 2);
      img[30] = i_t(12'h200, 0, 2, 12, OP_LOAD);
      load_image();

      @(negedge clk);
      #1;
      check32("rst pc", PC, S);
      check32("rst mem_addr", mem_addr, S);
      check32("rst mem_access", 32'(mem_access), 32'(MEM_ACCESS_WORD));
      check32("rst count", instructions_completed, 32'd0);
      check32("rst done", 32'(instruction_done), 32'd0);
      check32("rst halted", 32'(halted), 32'd0);
      check32("rst wr_ena", 32'(mem_wr_ena), 32'd0);

      @(negedge clk);
      rst_n = 1'b1;
      run_instr("addi x1",      6, 0, S + 32'h04, 0, 0);
      run_instr("add x2",       6, 0, S + 32'h08, 0, 0);
      run_instr("sw x2",        8, 3, S + 32'h0C, 0, 0);
      run_instr("addi x4",      6, 0, S + 32'h10, 0, 0);
      run_instr("sb x4",        8, 3, S + 32'h14, 0, 0);
      run_instr("lb x3",        9, 0, S + 32'h18, 0, 0);
      run_instr("lbu x5",       9, 0, S + 32'h1C, 0, 0);
      run_instr("sw x3",        8, 3, S + 32'h20, 0, 0);
      run_instr("sw x5",        8, 3, S + 32'h24, 0, 0);
      run_instr("jal x6",       5, 0, S + 32'h34, 0, 0);
      run_instr("jalr odd",     6, 0, S + 32'h28, 0, 0);
      run_instr("sw x6",        8, 3, S + 32'h2C, 0, 0);
      run_instr("beq taken",    5, 0, S + 32'h3C, 0, 0);
      run_instr("bne untaken",  5, 0, S + 32'h40, 0, 0);
      run_instr("blt taken",    5, 0, S + 32'h48, 0, 0);
      run_instr("bltu untaken", 5, 0, S + 32'h4C, 0, 0);
      run_instr("jal fwd",      5, 0, S + 32'h58, 0, 0);
      run_instr("beq back",     5, 0, S + 32'h50, 0, 0);
      run_instr("jal fwd2",     5, 0, S + 32'h5C, 0, 0);
      run_instr("lui x8",       6, 0, S + 32'h60, 0, 0);
      run_instr("auipc x9",     6, 0, S + 32'h64, 0, 0);
      run_instr("sw x8",        8, 3, S + 32'h68, 0, 0);
      run_instr("sw x9",        8, 3, S + 32'h6C, 0, 0);
      run_instr("sub stalled", 11, 0, S + 32'h70, 2, 5);
      run_instr("srai x11",     6, 0, S + 32'h74, 0, 0);
      run_instr("sw x11",       8, 3, S + 32'h78, 0, 0);
      exc_arm = 1'b1;
      halt_check("lw fault", 9, S + 32'h78);

      check32("mem sw x2",   mem[128], 32'h0000_000A);
      check32("mem sb 0x80", mem[129], 32'h0000_0080);
      check32("mem lb",      mem[130], 32'hFFFF_FF80);
      check32("mem lbu",     mem[131], 32'h0000_0080);
      check32("mem jal link", mem[132], 32'h1000_0028);
      check32("mem lui",     mem[133], 32'hABCD_E000);
      check32("mem auipc",   mem[134], 32'h1000_1060);
      check32("mem srai",    mem[135], 32'hFFFF_FFFD);
      check32("mem skipped", mem[136], 32'h0000_0000);

      rst_n = 1'b0;
      exc_arm = 1'b0;
      for (int i = 0; i < 256; i++) img[i] = 32'd0;
      img[0] = i_t(7, 0, 0, 1, OP_IMM);
      img[1] = s_t(12'h240, 1, 0, 2);
      load_image();
      #1;
      check32("rst2 halted", 32'(halted), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      exp_count = '0;
      run_instr("addi x1=7", 6, 0, S + 32'h04, 0, 0);
      repeat (6) @(negedge clk);
      #1;
      check32("mid store wr_ena", 32'(mem_wr_ena), 32'd1);
      rst_n = 1'b0;
      #1;
      check32("rst store wr_ena", 32'(mem_wr_ena), 32'd0);
      check32("rst store pc", PC, S);
      check32("rst store count", instructions_completed, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check32("rst store no commit", mem[144], 32'd0);

      for (int i = 0; i < 256; i++) img[i] = 32'd0;
      img[0] = i_t(1, 0, 0, 1, OP_IMM);
      img[1] = 32'h0000_007F;
      load_image();
      @(negedge clk);
      rst_n = 1'b1;
      exp_count = '0;
      run_instr("addi x1=1", 6, 0, S + 32'h04, 0, 0);
      halt_check("illegal op", 5, S + 32'h04);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
